// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline write-back and a buffered long-unit result FIFO; optional WB_ARB_KILL_EN drops stale buffered results
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg_i,
  input  logic [4:0]  wb_wd_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_wd_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq_o,
  output logic        lu_pending_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);
  logic [4:0]    mem_a [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic          push, pop, head_live;
  assign lu_ready_o   = count != FULL;
  assign lu_pending_o = count != '0;
  assign stallreq_o   = wait_cnt == LIM;
  assign push = lu_valid_i & lu_ready_o;
  assign pop  = !wb_wreg_i & lu_pending_o;
  // FIFO pointers, occupancy and head starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      wait_cnt <= (!lu_pending_o || pop) ? '0 : stallreq_o ? wait_cnt : wait_cnt + WW'(1);
    end
  end
  // FIFO storage, written on accepted long-unit results
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wp] <= lu_wd_i;
      mem_d[wp] <= lu_wdata_i;
    end
  end
`ifdef WB_ARB_KILL_EN
  logic [DEPTH-1:0] live;
  // a newer pipeline write to the same register kills buffered results; a same-cycle push stays live
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wb_wreg_i && wb_wd_i != 5'd0 && mem_a[i] == wb_wd_i) live[i] <= 1'b0;
      if (push) live[wp] <= 1'b1;
    end
  end
  assign head_live = live[rp];
`else
  assign head_live = 1'b1;
`endif
  // registered write port: pipeline first, else FIFO head; r0 and dead heads burn the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else if (wb_wreg_i) begin
      reg_we_o    <= 1'b1;
      reg_waddr_o <= wb_wd_i;
      reg_wdata_o <= wb_wdata_i;
    end else if (pop) begin
      reg_we_o    <= head_live && mem_a[rp] != 5'd0;
      reg_waddr_o <= mem_a[rp];
      reg_wdata_o <= mem_d[rp];
    end else begin
      reg_we_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench with a queue-based reference model of the write-port arbiter
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  typedef struct {logic [4:0] a; logic [31:0] d; bit live;} ent_t;
  typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_wreg_i = 1'b0, lu_valid_i = 1'b0;
  logic [4:0] wb_wd_i = '0, lu_wd_i = '0;
  logic [31:0] wb_wdata_i = '0, lu_wdata_i = '0;
  logic lu_ready_o, reg_we_o, stallreq_o, lu_pending_o;
  logic [4:0] reg_waddr_o;
  logic [31:0] reg_wdata_o;
  int pass = 0, total = 0, wait_m = 0;
  bit init_m = 0;
  ent_t q[$];
  wr_t expq[$];

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg_i(wb_wreg_i), .wb_wd_i(wb_wd_i), .wb_wdata_i(wb_wdata_i),
    .lu_valid_i(lu_valid_i), .lu_wd_i(lu_wd_i), .lu_wdata_i(lu_wdata_i),
    .lu_ready_o(lu_ready_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .stallreq_o(stallreq_o), .lu_pending_o(lu_pending_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s actual=%0h required=%0h", n, act, req);
  endfunction

  // monitor: every write the port shows must be the next one the model promised
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (rst) begin
      chk("rst_we", {31'd0, reg_we_o}, 0);
      chk("rst_waddr", {27'd0, reg_waddr_o}, 0);
      chk("rst_wdata", reg_wdata_o, 0);
    end else if (reg_we_o) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_write actual=%0d/%0h required=none", reg_waddr_o, reg_wdata_o);
      end else begin
        e = expq.pop_front();
        chk("waddr", {27'd0, reg_waddr_o}, {27'd0, e.a});
        chk("wdata", reg_wdata_o, e.d);
      end
    end else if (expq.size() != 0) begin
      e = expq.pop_front();
      total++;
      $display("FAIL missed_write actual=none required=%0d/%0h", e.a, e.d);
    end
  end

  task automatic cycle(input bit r, input bit wv, input logic [4:0] wd, input logic [31:0] wdt,
                       input bit lv, input logic [4:0] lwd, input logic [31:0] ld, output bit acc);
    bit rdy, had, popd;
    ent_t h;
    @(negedge clk);
    rst = r; wb_wreg_i = wv; wb_wd_i = wd; wb_wdata_i = wdt;
    lu_valid_i = lv; lu_wd_i = lwd; lu_wdata_i = ld;
    if (init_m) begin
      chk("lu_ready", {31'd0, lu_ready_o}, q.size() < DEPTH);
      chk("lu_pending", {31'd0, lu_pending_o}, q.size() != 0);
      chk("stallreq", {31'd0, stallreq_o}, wait_m == LIMIT);
    end
    acc = 0;
    if (r) begin
      q.delete();
      wait_m = 0;
      init_m = 1;
    end else begin
      rdy = q.size() < DEPTH;
      had = q.size() != 0;
      popd = 0;
      if (wv) begin
        expq.push_back('{wd, wdt});
`ifdef WB_ARB_KILL_EN
        if (wd != 0) foreach (q[i]) if (q[i].a == wd) q[i].live = 0;
`endif
      end else if (had) begin
        h = q.pop_front();
        popd = 1;
        if (h.a != 0 && h.live) expq.push_back('{h.a, h.d});
      end
      wait_m = (!had || popd) ? 0 : (wait_m < LIMIT ? wait_m + 1 : wait_m);
      if (lv && rdy) begin
        q.push_back('{lwd, ld, 1'b1});
        acc = 1;
      end
    end
  endtask

  initial begin
    bit acc, lv;
    logic [4:0] lwd;
    logic [31:0] ld;
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 1, 5'd7, 32'h77, acc);
    cycle(0, 1, 5'd3, 32'h11, 0, 0, 0, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 1, 5'd1, 32'hA1, 1, 5'd4, 32'h44, acc);
    cycle(0, 1, 5'd2, 32'hA2, 1, 5'd6, 32'h66, acc);
    repeat (10) cycle(0, 1, 5'd8, 32'hA3, 1, 5'd10, 32'h1010, acc);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 1, 5'd1, 32'hB1, 1, 5'd11, 32'hB11, acc);
    cycle(0, 1, 5'd1, 32'hB2, 1, 5'd12, 32'hB12, acc);
    cycle(1, 0, 0, 0, 0, 0, 0, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 1, 5'd1, 32'hC1, 1, 5'd9, 32'h99, acc);
    cycle(0, 1, 5'd9, 32'h22, 0, 0, 0, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 1, 5'd9, 32'h23, 1, 5'd9, 32'h98, acc);
    cycle(0, 0, 0, 0, 1, 5'd0, 32'h5A, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    lv = 0; lwd = 0; ld = 0;
    for (int n = 0; n < 600; n++) begin
      bit r;
      r = $urandom_range(0, 99) == 0;
      if (!lv && $urandom_range(0, 1) == 1) begin
        lv = 1;
        lwd = 5'($urandom_range(0, 7));
        ld = $urandom;
      end
      cycle(r, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom, lv, lwd, ld, acc);
      if (acc || r) lv = 0;
    end
    repeat (8) cycle(0, 0, 0, 0, 0, 0, 0, acc);
    @(negedge clk);
    chk("drained", q.size() + expq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
